// File: rtl/gray2bin_pipe.sv
// Gray-to-binary converter with a fixed-latency pipeline and step classification.
// Each valid sample is decoded and compared with the previous valid sample (the history).
// The result is flagged as +1, -1, a hold, or an illegal jump. All comparisons wrap mod 2^N.
// The full decode and the classification happen ahead of stage 0.
// The remaining STAGES-1 registers only delay the result, so the latency is exactly STAGES.
module gray2bin_pipe #(
    parameter int unsigned N      = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_gray,
    input  logic         err_clr,
    output logic         out_valid,
    output logic [N-1:0] out_bin,
    output logic         step_up,
    output logic         step_dn,
    output logic         step_err,
    output logic         err_sticky
);

    localparam int unsigned Last = STAGES - 1;

    logic [N-1:0] w_bin;
    logic [N-1:0] w_diff;
    logic         w_up;
    logic         w_dn;
    logic         w_err;

    logic [N-1:0] r_hist;
    logic         r_hist_vld;
    logic         r_err_sticky;

    // Per-stage state; flags are kept as {err, dn, up} and are zero in empty slots
    logic         r_vld [STAGES];
    logic [N-1:0] r_bin [STAGES];
    logic [2:0]   r_flg [STAGES];

    // Gray decode: bin[i] is the XOR of all gray bits from i upward
    always_comb begin
        w_bin = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_bin[i] = ^(in_gray >> i);
        end
    end

    // Classify the incoming sample against the history (modular difference)
    always_comb begin
        w_diff = w_bin - r_hist;
        w_up   = r_hist_vld && (w_diff == N'(1));
        w_dn   = r_hist_vld && (w_diff == {N{1'b1}});
        w_err  = r_hist_vld && (w_diff != '0) && !w_up && !w_dn;
    end

    // History register: only valid samples update it; idle cycles leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
        end else if (in_valid) begin
            r_hist     <= w_bin;
            r_hist_vld <= 1'b1;
        end
    end

    // Delay line: data advances only with a valid slot so the output value holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_bin[s] <= '0;
                r_flg[s] <= '0;
            end
        end else begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_bin[0] <= w_bin;
            end
            r_flg[0] <= in_valid ? {w_err, w_dn, w_up} : 3'b000;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_bin[s] <= r_bin[s-1];
                end
                r_flg[s] <= r_flg[s-1];
            end
        end
    end

    // Sticky error: a step_err output sets it; set beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (step_err) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    // Outputs come straight from the last stage
    always_comb begin
        out_valid  = r_vld[Last];
        out_bin    = r_bin[Last];
        step_up    = r_flg[Last][0];
        step_dn    = r_flg[Last][1];
        step_err   = r_flg[Last][2];
        err_sticky = r_err_sticky;
    end

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Directed bench for gray2bin_pipe with N=4 and STAGES=2.
// Inputs change 1 time unit after a rising edge, and outputs are checked at that same point.
module tb_gray2bin_pipe;

    localparam int unsigned N      = 4;
    localparam int unsigned STAGES = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_gray;
    logic         err_clr;
    logic         out_valid;
    logic [N-1:0] out_bin;
    logic         step_up;
    logic         step_dn;
    logic         step_err;
    logic         err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray2bin_pipe #(
        .N      (N),
        .STAGES (STAGES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_gray    (in_gray),
        .err_clr    (err_clr),
        .out_valid  (out_valid),
        .out_bin    (out_bin),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .step_err   (step_err),
        .err_sticky (err_sticky)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of input, then step past the sampling edge
    task automatic drive(input logic v, input logic [N-1:0] g, input logic clr);
        in_valid = v;
        in_gray  = g;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_gray  = '0;
        err_clr  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [N-1:0] b,
                              input logic up, input logic dn, input logic er);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, ".bin"},   32'(out_bin),   32'(b));
        check_eq({tag, ".up"},    32'(step_up),   32'(up));
        check_eq({tag, ".dn"},    32'(step_dn),   32'(dn));
        check_eq({tag, ".err"},   32'(step_err),  32'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 2 cycles, then idle: everything stays quiet
        do_reset(2);
        check_eq("rst.sticky", 32'(err_sticky), 32'd0);
        expect_out("rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 1'b0);
            expect_out($sformatf("idle%0d", i), 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
            check_eq($sformatf("idle%0d.sticky", i), 32'(err_sticky), 32'd0);
        end

        // Counting sequence: first sample has no history, then three +1 steps
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        expect_out("cnt0", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        expect_out("cnt1", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b0010, 1'b0);
        expect_out("cnt2", 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("cnt3", 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("cnthold", 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);

        // Wrap up: 1111 -> 0000
        do_reset(1);
        drive(1'b1, 4'b1000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
        expect_out("wrapup0", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("wrapup1", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Step down: 0100 -> 0011
        do_reset(1);
        drive(1'b1, 4'b0110, 1'b0);
        drive(1'b1, 4'b0010, 1'b0);
        expect_out("down0", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("down1", 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);

        // Illegal jump 0000 -> 0010, sticky set one cycle later, cleared by err_clr
        do_reset(1);
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        expect_out("jump0", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("jump1", 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
        check_eq("jump1.sticky", 32'(err_sticky), 32'd0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("jump2", 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        check_eq("jump2.sticky", 32'(err_sticky), 32'd1);
        drive(1'b0, 4'b0000, 1'b0);
        check_eq("jump3.sticky", 32'(err_sticky), 32'd1);
        drive(1'b0, 4'b0000, 1'b1);
        check_eq("clr.sticky", 32'(err_sticky), 32'd0);

        // Second jump 0010 -> 0000 with err_clr coincident with the step_err cycle
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("jumpb", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        check_eq("setwins.sticky", 32'(err_sticky), 32'd1);
        drive(1'b0, 4'b0000, 1'b0);
        check_eq("setwins2.sticky", 32'(err_sticky), 32'd1);
        drive(1'b0, 4'b0000, 1'b1);
        check_eq("clr2.sticky", 32'(err_sticky), 32'd0);

        // Idle gap between two samples does not disturb the history
        do_reset(1);
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("gap0", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("gap1", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("gap2", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        expect_out("gap3", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("gap4", 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);

        // Reset mid-flight discards 0101; rst also dominates a coincident in_valid
        do_reset(1);
        drive(1'b1, 4'b0111, 1'b0);
        drive(1'b1, 4'b0101, 1'b0);
        expect_out("flt0", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 4'b0011, 1'b1);
        rst = 1'b0;
        expect_out("fltrst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("flt1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 1'b0);
        expect_out("flt2", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        expect_out("flt3", 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        check_eq("flt3.sticky", 32'(err_sticky), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray2bin_pipe.md
GRAY2BIN_PIPE -- requirements
Module: gray2bin_pipe

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the code width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter STAGES, default 1, giving the number of pipeline register stages; legal range 1..N.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, which qualifies in_gray in the current cycle.
REQ-006 The block SHALL have port in_gray, input, N bits, the Gray-coded sample.
REQ-007 The block SHALL have port err_clr, input, 1 bit, which clears err_sticky.
REQ-008 The block SHALL have port out_valid, output, 1 bit, which qualifies out_bin and the step flags.
REQ-009 The block SHALL have port out_bin, output, N bits, the binary value of the sample.
REQ-010 The block SHALL have port step_up, output, 1 bit: the sample is the previous valid sample +1 mod 2^N.
REQ-011 The block SHALL have port step_dn, output, 1 bit: the sample is the previous valid sample -1 mod 2^N.
REQ-012 The block SHALL have port step_err, output, 1 bit: the sample is neither equal to the previous valid sample nor ±1 from it.
REQ-013 The block SHALL have port err_sticky, output, 1 bit, a latched record of any step_err.

Function
REQ-014 The block SHALL convert each sample as bin[N-1] = gray[N-1] and bin[i] = bin[i+1] XOR gray[i] for i = N-2 down to 0.
REQ-015 The block SHALL present each sample accepted with in_valid=1 in cycle t on out_valid/out_bin/step flags in cycle t+STAGES, with fixed latency and no backpressure.
REQ-016 The block SHALL allow the XOR chain to be split across the STAGES registers in any way, provided REQ-015 latency is exact.
REQ-017 The block SHALL drive out_valid low in any cycle with no sample emerging, and in such cycles out_bin SHALL hold its last value and step_up/step_dn/step_err SHALL be 0.
REQ-018 The block SHALL compare each valid sample against the most recent previous valid sample (the history), where cycles with in_valid=0 neither update nor clear the history.
REQ-019 The block SHALL treat the first valid sample after reset as having no history and SHALL output step_up=step_dn=step_err=0 for it.
REQ-020 The block SHALL output all step flags as 0 for a sample identical to the history (hold).
REQ-021 The block SHALL assert exactly one of step_up, step_dn, step_err for any other sample.
REQ-022 The block SHALL apply wrap-around to step detection: binary 2^N-1 followed by 0 gives step_up, and 0 followed by 2^N-1 gives step_dn.
REQ-023 The block SHALL set err_sticky to 1 in the cycle after an output cycle with step_err=1, and SHALL hold it until err_clr=1 clears it on the next edge.
REQ-024 The block SHALL let the set win when err_clr=1 coincides with an output cycle having step_err=1, leaving err_sticky at 1.
REQ-025 The block SHALL align step flags with the out_valid cycle of the sample they describe.

Reset
REQ-026 The block SHALL, on rst=1 at a clock edge, clear all pipeline valid bits, the history-present flag and err_sticky, and drive out_valid=0, out_bin=0, step_up=step_dn=step_err=0, err_sticky=0.
REQ-027 The block SHALL treat rst as dominant over in_valid and err_clr in the same cycle.
REQ-028 The block SHALL discard in-flight samples on reset mid-operation, with none emerging afterwards, and SHALL treat the next valid sample as first per REQ-019.

Verification (N=4, STAGES=2)
REQ-029 The bench SHALL cover: hold rst=1 for 2 cycles, then release with in_valid=0 -> out_valid=0, out_bin=0000, all flags 0, err_sticky=0 indefinitely.
REQ-030 The bench SHALL cover: in_gray 0000,0001,0011,0010 valid on consecutive cycles -> out_bin 0000,0001,0010,0011 two cycles later; step_up 0,1,1,1; step_dn=step_err=0.
REQ-031 The bench SHALL cover: in_gray 1000 then 0000 (wrap) -> out_bin 1111,0000; step_up on the second sample. Then in_gray 0110 then 0010 -> out_bin 0100,0011; step_dn on the second sample.
REQ-032 The bench SHALL cover: in_gray 0000 then 0011 -> out_bin 0010 with step_err=1 and err_sticky=1 the next cycle. Pulse err_clr alone -> 0. Repeat with err_clr in the same cycle as step_err -> err_sticky stays 1.
REQ-033 The bench SHALL cover: in_gray 0001 valid, then 3 idle cycles, then 0011 valid -> step_up on the second sample, and out_valid=0 with flags 0 during the gap.
REQ-034 The bench SHALL cover: rst=1 one cycle after 0101 is sent -> 0101 never appears on out_valid. The next valid 1111 -> out_bin 1010 with all step flags 0.
